// File: rtl/adc_pkg.sv
// Shared types and constants for the MCP3002 conversion sequencer.
package adc_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned BYTE_W = 8;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  localparam logic [BYTE_W-1:0] DUMMY_BYTE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_XFER0,
    S_REL0,
    S_LOAD1,
    S_XFER1,
    S_REL1,
    S_PUBLISH
  } state_t;

  // First command byte: leading zero pads the frame so the result lands byte-aligned.
  function automatic logic [BYTE_W-1:0] build_cmd(input logic ch);
    return {1'b0, CMD_START, CMD_SGL, ch, CMD_MSBF, 3'b000};
  endfunction

endpackage

// File: rtl/adc_sample_avg.sv
// Boxcar averager: emits the truncated mean of every 2^AVG_LOG2 input samples.
module adc_sample_avg
  import adc_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;

  assign sum = acc + ACC_W'(in_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (cnt == LAST) begin
          out_data  <= DATA_W'(sum >> AVG_LOG2);
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// MCP3002 conversion sequencer in front of a byte-wide SPI master.
// Build option ADC_AVG_EN routes results through adc_sample_avg before publishing.
module adc_sample_ctrl
  import adc_pkg::*;
#(
`ifdef ADC_AVG_EN
  parameter int unsigned AVG_LOG2   = 2,
`endif
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              channel,
  input  logic              clr_overrun,
  input  logic              spi_done,
  input  logic [BYTE_W-1:0] spi_received,
  output logic [BYTE_W-1:0] spi_to_send,
  output logic              spi_transmit,
  output logic              adc_cs_n,
  output logic              busy,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  period_cnt;
  logic              tick;
  logic [1:0]        rx0_lo;
  logic [BYTE_W-1:0] rx1;
  logic [BYTE_W-1:0] to_send_d;
  logic              transmit_d, cs_n_d, busy_d, publish_d;

  assign tick = (period_cnt == CNT_LAST) && enable;

  always_ff @(posedge clk) begin
    if (reset) period_cnt <= '0;
    else if (period_cnt == CNT_LAST) period_cnt <= '0;
    else period_cnt <= period_cnt + CNT_W'(1);
  end

  // Next state plus the next value of every registered output, derived from state_d.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:    if (tick) state_d = S_LOAD0;
      S_LOAD0:   state_d = S_XFER0;
      S_XFER0:   if (spi_done) state_d = S_REL0;
      S_REL0:    if (!spi_done) state_d = S_LOAD1;
      S_LOAD1:   state_d = S_XFER1;
      S_XFER1:   if (spi_done) state_d = S_REL1;
      S_REL1:    if (!spi_done) state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    to_send_d  = spi_to_send;
    if (state_d == S_LOAD0) to_send_d = build_cmd(channel);
    else if (state_d == S_LOAD1) to_send_d = DUMMY_BYTE;
    transmit_d = (state_d == S_XFER0) || (state_d == S_XFER1);
    cs_n_d     = (state_d == S_IDLE) || (state_d == S_PUBLISH);
    busy_d     = (state_d != S_IDLE);
    publish_d  = (state_d == S_PUBLISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      spi_to_send  <= '0;
      spi_transmit <= 1'b0;
      adc_cs_n     <= 1'b1;
      busy         <= 1'b0;
      rx0_lo       <= '0;
      rx1          <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      spi_to_send  <= to_send_d;
      spi_transmit <= transmit_d;
      adc_cs_n     <= cs_n_d;
      busy         <= busy_d;
      if (state == S_XFER0 && spi_done) rx0_lo <= spi_received[1:0];
      if (state == S_XFER1 && spi_done) rx1 <= spi_received;
      // A new overrun beats a simultaneous clear.
      if (tick && state != S_IDLE) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef ADC_AVG_EN
  adc_sample_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (state == S_PUBLISH),
    .in_data  ({rx0_lo, rx1}),
    .out_valid(sample_valid),
    .out_data (sample_data)
  );
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      sample_valid <= publish_d;
      if (publish_d) sample_data <= {rx0_lo, rx1};
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench for adc_sample_ctrl with a behavioural SPI master and ADC.
module tb_adc_sample_ctrl;

  localparam int unsigned SAMPLE_DIV = 64;
  localparam int BYTE_CYC = 16;

  logic       clk = 1'b0;
  logic       reset, enable, channel, clr_overrun, spi_done;
  logic [7:0] spi_received, spi_to_send;
  logic       spi_transmit, adc_cs_n, busy, sample_valid, overrun;
  logic [9:0] sample_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid = -1;
  bit chk_interval = 0;
  int done_len = 1;

  logic [7:0] rx0_val, rx1_val;
  logic [7:0] rx1_q[$];
  logic [7:0] exp_bytes[$];
  logic [9:0] exp_samples[$];

  adc_sample_ctrl #(
`ifdef ADC_AVG_EN
    .AVG_LOG2(2),
`endif
    .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .channel     (channel),
    .clr_overrun (clr_overrun),
    .spi_done    (spi_done),
    .spi_received(spi_received),
    .spi_to_send (spi_to_send),
    .spi_transmit(spi_transmit),
    .adc_cs_n    (adc_cs_n),
    .busy        (busy),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI master + ADC model: 16-cycle byte, done held for done_len cycles.
  initial begin : spi_model
    logic [7:0] b;
    bit abort, held;
    spi_done = 1'b0;
    spi_received = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_transmit) begin
        b = spi_to_send;
        if (exp_bytes.size() == 0) check("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
        else check("spi_to_send", 32'(b), 32'(exp_bytes.pop_front()));
        check("cs_low_in_xfer", 32'(adc_cs_n), 32'd0);
        abort = 0;
        held = 1;
        for (int i = 1; i < BYTE_CYC; i++) begin
          @(negedge clk);
          if (!spi_transmit) begin
            abort = 1;
            break;
          end
          if (spi_to_send !== b) held = 0;
        end
        if (!abort) begin
          check("to_send_held", 32'(held), 32'd1);
          if (b == 8'h00) spi_received = (rx1_q.size() > 0) ? rx1_q.pop_front() : rx1_val;
          else spi_received = rx0_val;
          spi_done = 1'b1;
          repeat (done_len) @(negedge clk);
          spi_done = 1'b0;
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every sample_valid.
  initial begin : monitor
    bit prev_valid;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (prev_valid) check("valid_one_cycle", 32'(sample_valid), 32'd0);
      if (!reset && sample_valid) begin
        if (exp_samples.size() == 0) check("unexpected_sample", 32'(sample_data), 32'hFFFF_FFFF);
        else check("sample_data", 32'(sample_data), 32'(exp_samples.pop_front()));
        check("cs_high_at_valid", 32'(adc_cs_n), 32'd1);
        if (chk_interval && last_valid >= 0) check("valid_interval", 32'(cyc - last_valid), 32'd64);
        last_valid = cyc;
        n_valid++;
      end
      prev_valid = sample_valid && !reset;
    end
  end

  task automatic wait_samples(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(name, 32'(n_valid >= target), 32'd1);
  endtask

  task automatic wait_xfer(input logic [7:0] want, input int budget, input string name);
    int k;
    k = 0;
    while (!(spi_transmit && spi_to_send == want) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(spi_transmit && spi_to_send == want), 32'd1);
  endtask

  task automatic push_frame(input logic ch, input logic [9:0] sample, input bit with_sample);
    exp_bytes.push_back({1'b0, 1'b1, 1'b1, ch, 1'b1, 3'b000});
    exp_bytes.push_back(8'h00);
    if (with_sample) exp_samples.push_back(sample);
  endtask

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit saw_busy;
    reset = 1'b1; enable = 1'b0; channel = 1'b1; clr_overrun = 1'b0;
    rx0_val = 8'hFE; rx1_val = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_transmit", 32'(spi_transmit), 32'd0);
    check("rst_to_send", 32'(spi_to_send), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample", 32'(sample_data), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Reset in the middle of the first byte aborts the frame.
    exp_bytes.push_back(8'h78);
    enable = 1'b1;
    wait_xfer(8'h78, 200, "t1_reach_xfer0");
    repeat (3) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("t1_cs_n", 32'(adc_cs_n), 32'd1);
    check("t1_transmit", 32'(spi_transmit), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_to_send", 32'(spi_to_send), 32'd0);
    reset = 1'b0;
    exp_bytes.delete();
    repeat (40) @(negedge clk);

`ifndef ADC_AVG_EN
    // Four back-to-back frames: command 0x78, result 0x2A5, 64-cycle cadence.
    for (int f = 0; f < 4; f++) push_frame(1'b1, 10'h2A5, 1);
    last_valid = -1;
    chk_interval = 1;
    enable = 1'b1;
    wait_samples(n_valid + 4, 4 * 64 + 120, "t3_four_samples");
    enable = 1'b0;
    chk_interval = 0;
    check("t3_overrun", 32'(overrun), 32'd0);
    repeat (10) @(negedge clk);

    // enable drops during the second byte: frame still publishes, then idle.
    rx0_val = 8'h01; rx1_val = 8'h23; channel = 1'b0;
    push_frame(1'b0, 10'h123, 1);
    enable = 1'b1;
    wait_xfer(8'h00, 200, "t5_reach_xfer1");
    enable = 1'b0;
    wait_samples(n_valid + 1, 100, "t5_published");
    saw_busy = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("t5_no_new_frame", 32'(saw_busy), 32'd0);
    check("t5_cs_idle", 32'(adc_cs_n), 32'd1);

    // Stretched done makes the frame outlast the tick period.
    rx0_val = 8'hFE; rx1_val = 8'hA5; channel = 1'b1;
    done_len = 60;
    push_frame(1'b1, 10'h2A5, 1);
    enable = 1'b1;
    wait_samples(n_valid + 1, 400, "t4_published");
    enable = 1'b0;
    check("t4_overrun_set", 32'(overrun), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 32'd0);
    done_len = 1;
    repeat (10) @(negedge clk);
`else
    // Averaging four results 100,101,102,105 -> 102.
    rx0_val = 8'h00; channel = 1'b1;
    rx1_q.push_back(8'h64); rx1_q.push_back(8'h65);
    rx1_q.push_back(8'h66); rx1_q.push_back(8'h69);
    for (int f = 0; f < 4; f++) push_frame(1'b1, 10'd0, 0);
    exp_samples.push_back(10'd102);
    enable = 1'b1;
    wait_samples(n_valid + 1, 4 * 64 + 150, "t6_avg_output");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_bytes_consumed", 32'(exp_bytes.size()), 32'd0);
`endif

    check("samples_drained", 32'(exp_samples.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
